// File: rtl/game_flow_controller.sv
// game_flow_controller
// Top-level breakout sequencer: attract -> serve pause -> play -> level-clear
// pause / game over -> restart. Tracks lives and level, paces the pauses in
// video frames and drives the game-over overlay's trigger and reset pulses.
// Every output is a register; pulses last exactly the first cycle of the
// state that produces them.

module game_flow_controller #(
    parameter int LIVES_INIT         = 3,
    parameter int NUM_LEVELS         = 4,
    parameter int SERVE_DELAY_FRAMES = 60,
    parameter int CLEAR_DELAY_FRAMES = 120
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic       start_btn,
    input  logic       ball_lost,
    input  logic       bricks_cleared,
    input  logic       game_over_complete,
    output logic       trigger_game_over,
    output logic       overlay_reset,
    output logic       serve_ball,
    output logic       level_load,
    output logic       game_active,
    output logic [1:0] level,
    output logic [2:0] lives,
    output logic [1:0] overlay_sel
);

    localparam int MAX_DELAY = (SERVE_DELAY_FRAMES > CLEAR_DELAY_FRAMES) ?
                               SERVE_DELAY_FRAMES : CLEAR_DELAY_FRAMES;
    localparam int CNT_W     = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;

    localparam logic [CNT_W-1:0] SERVE_LAST  = CNT_W'(SERVE_DELAY_FRAMES - 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST  = CNT_W'(CLEAR_DELAY_FRAMES - 1);
    localparam logic [2:0]       LIVES_START = 3'(LIVES_INIT);
    localparam logic [1:0]       LEVEL_LAST  = 2'(NUM_LEVELS - 1);

    localparam logic [1:0] OVL_NONE      = 2'd0;
    localparam logic [1:0] OVL_TITLE     = 2'd1;
    localparam logic [1:0] OVL_CLEAR     = 2'd2;
    localparam logic [1:0] OVL_GAME_OVER = 2'd3;

    typedef enum logic [2:0] {
        ST_ATTRACT     = 3'd0,
        ST_SERVE_WAIT  = 3'd1,
        ST_PLAY        = 3'd2,
        ST_LEVEL_CLEAR = 3'd3,
        ST_GAME_OVER   = 3'd4,
        ST_RESTART     = 3'd5
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_frame_cnt;
    // High during the first cycle of a state entered by a transition. Reset
    // leaves it low so start_btn is honoured straight out of reset, while the
    // ATTRACT entry from RESTART makes a held button wait one extra cycle.
    logic             r_first;
    logic             r_trigger_game_over;
    logic             r_overlay_reset;
    logic             r_serve_ball;
    logic             r_level_load;
    logic             r_game_active;
    logic [1:0]       r_level;
    logic [2:0]       r_lives;
    logic [1:0]       r_overlay_sel;

    // Level index wraps at NUM_LEVELS, not at the 2-bit field width.
    logic [1:0] w_level_next;
    assign w_level_next = (r_level == LEVEL_LAST) ? 2'd0 : r_level + 2'd1;

    // Sequencer: state, frame pacing, lives/level bookkeeping and all outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state             <= ST_ATTRACT;
            r_frame_cnt         <= '0;
            r_first             <= 1'b0;
            r_trigger_game_over <= 1'b0;
            r_overlay_reset     <= 1'b0;
            r_serve_ball        <= 1'b0;
            r_level_load        <= 1'b0;
            r_game_active       <= 1'b0;
            r_level             <= 2'd0;
            r_lives             <= LIVES_START;
            r_overlay_sel       <= OVL_TITLE;
        end else begin
            // NOTE: non-blocking defaults drop every pulse after one cycle; a
            // transition below overrides them because the last assignment wins.
            r_trigger_game_over <= 1'b0;
            r_overlay_reset     <= 1'b0;
            r_serve_ball        <= 1'b0;
            r_level_load        <= 1'b0;
            r_first             <= 1'b0;

            case (r_state)
                ST_ATTRACT: begin
                    if (start_btn && !r_first) begin
                        r_state       <= ST_SERVE_WAIT;
                        r_frame_cnt   <= '0;
                        r_first       <= 1'b1;
                        r_level_load  <= 1'b1;
                        r_overlay_sel <= OVL_NONE;
                    end
                end

                ST_SERVE_WAIT: begin
                    if (frame_tick) begin
                        if (r_frame_cnt == SERVE_LAST) begin
                            r_state       <= ST_PLAY;
                            r_frame_cnt   <= '0;
                            r_first       <= 1'b1;
                            r_serve_ball  <= 1'b1;
                            r_game_active <= 1'b1;
                        end else begin
                            r_frame_cnt <= r_frame_cnt + CNT_W'(1);
                        end
                    end
                end

                ST_PLAY: begin
                    // A clear in the same cycle as a lost ball takes priority
                    // and leaves lives untouched.
                    if (bricks_cleared) begin
                        r_state       <= ST_LEVEL_CLEAR;
                        r_frame_cnt   <= '0;
                        r_first       <= 1'b1;
                        r_game_active <= 1'b0;
                        r_overlay_sel <= OVL_CLEAR;
                    end else if (ball_lost) begin
                        r_frame_cnt   <= '0;
                        r_first       <= 1'b1;
                        r_game_active <= 1'b0;
                        if (r_lives > 3'd1) begin
                            r_lives <= r_lives - 3'd1;
                            r_state <= ST_SERVE_WAIT;
                        end else begin
                            r_lives             <= 3'd0;
                            r_state             <= ST_GAME_OVER;
                            r_trigger_game_over <= 1'b1;
                            r_overlay_sel       <= OVL_GAME_OVER;
                        end
                    end
                end

                ST_LEVEL_CLEAR: begin
                    if (frame_tick) begin
                        if (r_frame_cnt == CLEAR_LAST) begin
                            r_state       <= ST_SERVE_WAIT;
                            r_frame_cnt   <= '0;
                            r_first       <= 1'b1;
                            r_level       <= w_level_next;
                            r_level_load  <= 1'b1;
                            r_overlay_sel <= OVL_NONE;
                        end else begin
                            r_frame_cnt <= r_frame_cnt + CNT_W'(1);
                        end
                    end
                end

                ST_GAME_OVER: begin
                    // A completion flag left high from a previous game is not
                    // trusted on the entry cycle.
                    if (game_over_complete && !r_first) begin
                        r_state         <= ST_RESTART;
                        r_frame_cnt     <= '0;
                        r_first         <= 1'b1;
                        r_overlay_reset <= 1'b1;
                        r_lives         <= LIVES_START;
                        r_level         <= 2'd0;
                        r_overlay_sel   <= OVL_TITLE;
                    end
                end

                ST_RESTART: begin
                    r_state       <= ST_ATTRACT;
                    r_frame_cnt   <= '0;
                    r_first       <= 1'b1;
                    r_overlay_sel <= OVL_TITLE;
                end

                default: begin
                    r_state       <= ST_ATTRACT;
                    r_frame_cnt   <= '0;
                    r_first       <= 1'b0;
                    r_game_active <= 1'b0;
                    r_lives       <= LIVES_START;
                    r_level       <= 2'd0;
                    r_overlay_sel <= OVL_TITLE;
                end
            endcase
        end
    end

    assign trigger_game_over = r_trigger_game_over;
    assign overlay_reset     = r_overlay_reset;
    assign serve_ball        = r_serve_ball;
    assign level_load        = r_level_load;
    assign game_active       = r_game_active;
    assign level             = r_level;
    assign lives             = r_lives;
    assign overlay_sel       = r_overlay_sel;

endmodule

// File: doc/game_flow_controller.md
Name: game_flow_controller

Overview:
- Top-level game sequencer for the breakout design. It tracks lives and level, paces serve and level-clear pauses in video frames, and triggers the red "GAME OVER" overlay.
- It waits for that overlay's completion flag, then clears the overlay and returns to attract mode.
- Sits between the ball/brick logic and the overlay/pixel mux; it owns the game-over overlay's trigger and reset inputs.

Parameters:
LIVES_INIT, 3, lives loaded at game start (1..7)
NUM_LEVELS, 4, number of levels; level index wraps to 0 after NUM_LEVELS-1
SERVE_DELAY_FRAMES, 60, frames of pause before each serve (>=1)
CLEAR_DELAY_FRAMES, 120, frames of pause after a level is cleared (>=1)

Ports:
clk  in  1  system clock, 50 MHz
reset_n  in  1  asynchronous active-low reset
frame_tick  in  1  one-cycle pulse per video frame
start_btn  in  1  level-sensitive start request
ball_lost  in  1  one-cycle pulse: ball passed paddle
bricks_cleared  in  1  one-cycle pulse: last brick of level destroyed
game_over_complete  in  1  overlay finished its timed display (stays high until overlay reset)
trigger_game_over  out  1  one-cycle pulse starting the overlay
overlay_reset  out  1  one-cycle active-high pulse clearing the overlay back to idle
serve_ball  out  1  one-cycle pulse: ball logic launches ball
level_load  out  1  one-cycle pulse: brick logic loads layout for `level`
game_active  out  1  high only in PLAY
level  out  2  current level index
lives  out  3  remaining lives
overlay_sel  out  2  0 none, 1 title, 2 level-clear banner, 3 game over

Behaviour:
- Register timing: all outputs are registered. Asynchronous reset values:
  - state ATTRACT, lives=LIVES_INIT, level=0, overlay_sel=1
  - all pulses 0, game_active=0, frame counter 0
- States: ATTRACT, SERVE_WAIT, PLAY, LEVEL_CLEAR, GAME_OVER, RESTART.
- Pulse/state timing: each pulse output is high for exactly the first clk cycle spent in the state that produces it. Latency from the causing input to the pulse is 1 cycle.
- Frame counter:
  - Clears on every state entry.
  - Increments on each frame_tick while in SERVE_WAIT or LEVEL_CLEAR.
  - A frame_tick in the entry cycle is counted.
  - The state exits on the cycle where frame_tick is high and counter==DELAY-1, i.e. after exactly DELAY ticks.
- ATTRACT:
  - overlay_sel=1.
  - start_btn high -> SERVE_WAIT, emitting level_load (lives=LIVES_INIT, level=0 already hold).
  - start_btn is ignored in every other state.
- SERVE_WAIT:
  - overlay_sel=0.
  - After SERVE_DELAY_FRAMES ticks -> PLAY, emitting serve_ball.
  - ball_lost and bricks_cleared are ignored here.
- PLAY:
  - game_active=1, overlay_sel=0.
  - bricks_cleared -> LEVEL_CLEAR.
  - ball_lost with lives>1: lives decrements, -> SERVE_WAIT.
  - ball_lost with lives==1: lives=0, -> GAME_OVER.
  - Both pulses in the same cycle: bricks_cleared wins and lives are unchanged.
- LEVEL_CLEAR:
  - overlay_sel=2.
  - After CLEAR_DELAY_FRAMES ticks: level increments (NUM_LEVELS-1 wraps to 0), -> SERVE_WAIT, emitting level_load with the new level value in the same cycle.
- GAME_OVER:
  - overlay_sel=3, trigger_game_over pulses on entry.
  - Waits indefinitely for game_over_complete==1, then -> RESTART.
  - A game_over_complete already high on the entry cycle is ignored; it is sampled from the second cycle on.
- RESTART:
  - Lasts one cycle: overlay_reset=1, lives=LIVES_INIT, level=0, overlay_sel=1.
  - Next state is ATTRACT.
  - start_btn is not sampled until the cycle after ATTRACT is entered. A held button therefore restarts the game on the 2nd cycle in ATTRACT.
- Width rules:
  - lives never underflows below 0.
  - level arithmetic is modulo NUM_LEVELS, not modulo 4.
- Reset mid-operation: reset_n low in any state returns all registers to reset values immediately. No pulse is emitted on release.
- Illegal state encodings -> ATTRACT.

Test Plan:
- Reset then start_btn=1 for one cycle -> level_load pulse next cycle. serve_ball pulse follows exactly 60 frame_ticks later, and game_active=1 after it.
- In PLAY with lives=3, three ball_lost pulses (each followed by serve) -> lives 2, 1, then 0. After the third: state GAME_OVER, trigger_game_over pulses once, overlay_sel=3.
- In GAME_OVER, hold game_over_complete=0 for 1000 cycles -> no exit. Raise it -> one overlay_reset pulse, lives=3, level=0, overlay_sel=1 the following cycle.
- In PLAY on level 3 (NUM_LEVELS=4), pulse bricks_cleared -> overlay_sel=2. After 120 frame_ticks: level=0, level_load pulse, then SERVE_WAIT.
- In PLAY with lives=1, ball_lost and bricks_cleared in the same cycle -> LEVEL_CLEAR, lives stays 1, no trigger_game_over.
- Assert reset_n=0 asynchronously mid-SERVE_WAIT and mid-GAME_OVER -> outputs at reset values within the same cycle. No serve_ball, trigger_game_over or overlay_reset pulse after release.
